// File: rtl/uart_rcv_block.sv
// Serial receiver: start-edge detect, mid-bit sampling, stop check, one-deep holding register.
// Latency: data_ready rises HALF+(DATA_BITS+1)*CLKS_PER_BIT+2 clks after the synchronised start edge.
// Backpressure: none on the line; an unread word is overwritten by the next good frame and overrun_error is flagged.
module uart_rcv_block #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [BW-1:0] BITS_M1     = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE     = BW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_LOAD  = 3'd4
    } state_t;

    // Line synchroniser and edge history
    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       start_edge;

    // Frame state
    state_t                 state_q,      state_d;
    logic [CW-1:0]          clk_cnt_q,    clk_cnt_d;
    logic [BW-1:0]          bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,      shift_d;
    logic                   stop_bit_q,   stop_bit_d;

    // Holding register and status
    logic [DATA_BITS-1:0]   rx_data_q,    rx_data_d;
    logic                   data_ready_q, data_ready_d;
    logic                   overrun_q,    overrun_d;
    logic                   framing_q,    framing_d;

    // Two-flop synchroniser plus previous-value flop; fill/armed make sure the
    // receiver has seen a real synchronised 1 before accepting a start, so a
    // line held low through reset does not look like a falling edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & sync2_q);
        end
    end

    assign start_edge = armed_q & prev_q & ~sync2_q;

    // Frame FSM and holding-register state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '1;
            stop_bit_q   <= 1'b1;
            rx_data_q    <= '1;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            stop_bit_q   <= stop_bit_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            framing_q    <= framing_d;
        end
    end

    // Next-state: bit timing, sampling, stop check and read handshake
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        stop_bit_d   = stop_bit_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;
        framing_d    = framing_q;

        // Consumer read; the LOAD cycle owns these flags and handles the read itself
        if (state_q != ST_LOAD && data_read && data_ready_q) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    framing_d = 1'b0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_HALF_M1) begin
                    clk_cnt_d = '0;
                    // A line back at 1 by mid start bit is a glitch, not a frame
                    state_d   = sync2_q ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {sync2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == BITS_M1) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d  = '0;
                    stop_bit_d = sync2_q;
                    state_d    = ST_LOAD;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_LOAD: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
                if (stop_bit_q) begin
                    rx_data_d    = shift_q;
                    data_ready_d = 1'b1;
                    // Unread word being replaced: flag it unless it is read right now
                    if (data_ready_q) begin
                        overrun_d = ~data_read;
                    end
                end else begin
                    framing_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rcv_block.sv
// Directed bench for uart_rcv_block with DATA_BITS=8, CLKS_PER_BIT=10.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Expected values are hand-derived constants per step.
module tb_uart_rcv_block;

    logic       clk;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int errs   = 0;
    int checks = 0;

    uart_rcv_block #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (10)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rxd, input logic rdy,
                           input logic ovr, input logic frm);
        chk({tag, ".rx_data"}, rx_data, rxd);
        chk({tag, ".data_ready"}, data_ready, rdy);
        chk({tag, ".overrun"}, overrun_error, ovr);
        chk({tag, ".framing"}, framing_error, frm);
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
    endtask

    // Drives one 100-clk frame starting just after an edge E.
    // mode 1: data_ready must be 0 after E+98 and 1 after E+99.
    // mode 2: framing_error must still be 1 after E+2 and clear after E+3.
    // mode 3: data_read pulsed in the LOAD cycle (between E+98 and E+99).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int mode);
        serial_in = 1'b0;
        if (mode == 2) begin
            tick(2);
            chk("frm_hold_before_edge", framing_error, 1'b1);
            tick(1);
            chk("frm_clear_at_start", framing_error, 1'b0);
            tick(7);
        end else begin
            tick(10);
        end
        for (int i = 0; i < 8; i++) begin
            serial_in = d[i];
            tick(10);
        end
        serial_in = stop;
        if (mode == 1) begin
            tick(8);
            chk("rdy_not_early", data_ready, 1'b0);
            tick(1);
            chk("rdy_exact", data_ready, 1'b1);
            chk("rx_exact", rx_data, d);
            tick(1);
        end else if (mode == 3) begin
            tick(8);
            data_read = 1'b1;
            tick(1);
            data_read = 1'b0;
            chk("load_read.rdy", data_ready, 1'b1);
            chk("load_read.ovr", overrun_error, 1'b0);
            chk("load_read.rx", rx_data, d);
            tick(1);
        end else begin
            tick(10);
        end
        serial_in = 1'b1;
    endtask

    initial begin
        n_rst     = 1'b0;
        serial_in = 1'b0;
        data_read = 1'b0;

        // 1. Reset with the line low, then release with it still low
        tick(3);
        chk_all("reset", 8'hFF, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        tick(120);
        chk_all("low_after_reset", 8'hFF, 1'b0, 1'b0, 1'b0);
        serial_in = 1'b1;
        tick(5);

        // 2. Good frame 0xA5 with exact latency, then read
        send_frame(8'hA5, 1'b1, 1);
        chk_all("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        read_pulse();
        chk("a5_read.rdy", data_ready, 1'b0);
        tick(5);
        // Read with nothing pending does nothing
        read_pulse();
        chk_all("idle_read", 8'hA5, 1'b0, 1'b0, 1'b0);

        // 3. False start: low 3 clks, then high
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(20);
        chk_all("false_start", 8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 0);
        tick(2);
        chk_all("3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        read_pulse();
        tick(5);

        // 4. Bad stop bit, then a good frame clears framing_error at its start
        send_frame(8'h5A, 1'b0, 0);
        tick(5);
        chk_all("5a_framing", 8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b1, 2);
        tick(2);
        chk_all("0f", 8'h0F, 1'b1, 1'b0, 1'b0);
        read_pulse();
        tick(5);

        // 5. Back-to-back frames, no read -> overrun
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        tick(2);
        chk_all("overrun", 8'h22, 1'b1, 1'b1, 1'b0);
        read_pulse();
        chk_all("overrun_read", 8'h22, 1'b0, 1'b0, 1'b0);
        tick(5);

        // 6. Reset in the middle of data bit 4
        serial_in = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            serial_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(10);
        end
        serial_in = 1'b1;
        tick(5);
        n_rst = 1'b0;
        tick(2);
        chk_all("mid_reset", 8'hFF, 1'b0, 1'b0, 1'b0);
        tick(2);
        n_rst = 1'b1;
        tick(5);
        send_frame(8'hFE, 1'b1, 3);
        tick(2);
        chk_all("fe", 8'hFE, 1'b1, 1'b0, 1'b0);
        // Unread 0xFE overwritten -> overrun; then a read in LOAD clears it
        send_frame(8'hC3, 1'b1, 0);
        tick(2);
        chk_all("c3_overrun", 8'hC3, 1'b1, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 3);
        tick(2);
        chk_all("81", 8'h81, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
